// File: rtl/watch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : watch_ctrl_pkg
// Purpose  : Shared definitions for the watch front-panel controller and the
//            display mux: mode codes, button indices, control FSM state
//            encoding and a mode-advance helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package watch_ctrl_pkg;

  localparam logic [2:0] MODE_WATCH     = 3'd0;
  localparam logic [2:0] MODE_STOPWATCH = 3'd1;
  localparam logic [2:0] MODE_ALARM     = 3'd2;
  localparam logic [2:0] MODE_DAY       = 3'd3;
  localparam int         NUM_MODES      = 4;

  // Bit positions of the four buttons inside the packed button vectors.
  localparam int BTN_MODE = 0;
  localparam int BTN_SET  = 1;
  localparam int BTN_NEXT = 2;
  localparam int BTN_UP   = 3;
  localparam int NUM_BTNS = 4;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_EDIT = 1'b1
  } ctrl_state_t;

  // Cycle watch -> stopwatch -> alarm -> day -> watch.
  function automatic logic [2:0] next_mode(input logic [2:0] m);
    if (m >= 3'(NUM_MODES - 1)) begin
      return MODE_WATCH;
    end
    return m + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : One push-button channel: 2-flop synchronizer, debounce counter
//            and a 1-cycle press pulse on an accepted 0->1 level change.
// Ports    : clk      in  system clock
//            reset    in  asynchronous active-high reset
//            i_btn    in  raw asynchronous button level (1 = pressed)
//            o_press  out registered 1-cycle pulse per accepted press
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Everything resets to "pressed" so a button held through reset is treated
  // as already down and must be released before it can produce a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // This is the DEBOUNCE_CYC-th consecutive differing sample.
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/watch_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : watch_mode_sequencer
// Purpose  : Front-panel controller: debounces four buttons, cycles display
//            mode and runs the digit edit session (cursor, strobes, blink).
// Ports    : clk            in   system clock
//            reset          in   asynchronous active-high reset
//            btn_mode/set/next/up in raw button levels (1 = pressed)
//            mode[2:0]      out  displayed mode (0 watch .. 3 day)
//            edit_active    out  edit session open
//            cursor[1:0]    out  edited digit (3 = leftmost)
//            inc_strobe     out  increment digit [cursor] of datapath [mode]
//            commit_strobe  out  load edited value into datapath [mode]
//            cancel_strobe  out  discard edited value
//            blank[3:0]     out  per-digit blank mask
// Revision : 1.0 - initial release
// ============================================================================
module watch_mode_sequencer
  import watch_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int BLINK_HALF   = 8,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_next,
  input  logic       btn_up,
  output logic [2:0] mode,
  output logic       edit_active,
  output logic [1:0] cursor,
  output logic       inc_strobe,
  output logic       commit_strobe,
  output logic       cancel_strobe,
  output logic [3:0] blank
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_press;

  assign w_raw = {btn_up, btn_next, btn_set, btn_mode};

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (w_raw[g]),
      .o_press (w_press[g])
    );
  end

  ctrl_state_t   r_state;
  logic [2:0]    r_mode;
  logic [1:0]    r_cursor;
  logic          r_inc;
  logic          r_commit;
  logic          r_cancel;
  logic [3:0]    r_blank;
  logic [IW-1:0] r_idle;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;

  ctrl_state_t   w_state_n;
  logic [2:0]    w_mode_n;
  logic [1:0]    w_cursor_n;
  logic          w_inc_n;
  logic          w_commit_n;
  logic          w_cancel_n;
  logic [3:0]    w_blank_n;
  logic [IW-1:0] w_idle_n;
  logic [BW-1:0] w_bcnt_n;
  logic          w_phase_n;
  logic          w_any_ev;

  assign w_any_ev = |w_press;

  always_comb begin
    w_state_n  = r_state;
    w_mode_n   = r_mode;
    w_cursor_n = r_cursor;
    w_inc_n    = 1'b0;
    w_commit_n = 1'b0;
    w_cancel_n = 1'b0;
    w_idle_n   = r_idle;
    w_bcnt_n   = r_bcnt;
    w_phase_n  = r_phase;

    case (r_state)
      ST_RUN: begin
        // Timers held at zero so EDIT always starts with a visible digit.
        w_idle_n   = '0;
        w_bcnt_n   = '0;
        w_phase_n  = 1'b0;
        w_cursor_n = 2'd3;
        if (w_press[BTN_MODE]) begin
          w_mode_n = next_mode(r_mode);
        end else if (w_press[BTN_SET] && (r_mode != MODE_STOPWATCH)) begin
          w_state_n = ST_EDIT;
        end
      end

      ST_EDIT: begin
        if (w_any_ev) begin
          w_idle_n  = '0;
          w_bcnt_n  = '0;
          w_phase_n = 1'b0;
        end else begin
          w_idle_n = (r_idle == IW'(IDLE_TIMEOUT)) ? r_idle : r_idle + IW'(1);
          if (r_bcnt == BW'(BLINK_HALF - 1)) begin
            w_bcnt_n  = '0;
            w_phase_n = ~r_phase;
          end else begin
            w_bcnt_n = r_bcnt + BW'(1);
          end
        end

        if (w_press[BTN_MODE]) begin
          w_cancel_n = 1'b1;
          w_state_n  = ST_RUN;
        end else if (w_press[BTN_SET]) begin
          w_commit_n = 1'b1;
          w_state_n  = ST_RUN;
        end else if (w_press[BTN_NEXT]) begin
          w_cursor_n = r_cursor - 2'd1;  // 0 wraps naturally to 3
        end else if (w_press[BTN_UP]) begin
          w_inc_n = 1'b1;
        end else if (r_idle == IW'(IDLE_TIMEOUT - 1)) begin
          // This idle cycle is the IDLE_TIMEOUT-th one in a row.
          w_cancel_n = 1'b1;
          w_state_n  = ST_RUN;
        end

        if (w_state_n == ST_RUN) begin
          w_cursor_n = 2'd3;
        end
      end

      default: begin
        w_state_n = ST_RUN;
      end
    endcase

    w_blank_n = (w_state_n == ST_EDIT) ? (4'(w_phase_n) << w_cursor_n) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_RUN;
      r_mode   <= MODE_WATCH;
      r_cursor <= 2'd3;
      r_inc    <= 1'b0;
      r_commit <= 1'b0;
      r_cancel <= 1'b0;
      r_blank  <= 4'b0000;
      r_idle   <= '0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_mode   <= w_mode_n;
      r_cursor <= w_cursor_n;
      r_inc    <= w_inc_n;
      r_commit <= w_commit_n;
      r_cancel <= w_cancel_n;
      r_blank  <= w_blank_n;
      r_idle   <= w_idle_n;
      r_bcnt   <= w_bcnt_n;
      r_phase  <= w_phase_n;
    end
  end

  assign mode          = r_mode;
  assign edit_active   = (r_state == ST_EDIT);
  assign cursor        = r_cursor;
  assign inc_strobe    = r_inc;
  assign commit_strobe = r_commit;
  assign cancel_strobe = r_cancel;
  assign blank         = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_watch_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_watch_mode_sequencer
// Purpose  : Self-checking bench for watch_mode_sequencer: table of button
//            segments with expected results, hand-written corner sequences
//            and randomized button activity against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_watch_mode_sequencer;

  localparam int DEB = 4;
  localparam int BH  = 8;
  localparam int IT  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_up = 1'b0;
  logic [2:0] mode;
  logic       edit_active;
  logic [1:0] cursor;
  logic       inc_strobe;
  logic       commit_strobe;
  logic       cancel_strobe;
  logic [3:0] blank;

  always #5 clk = ~clk;

  watch_mode_sequencer #(
    .DEBOUNCE_CYC (DEB),
    .BLINK_HALF   (BH),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_set       (btn_set),
    .btn_next      (btn_next),
    .btn_up        (btn_up),
    .mode          (mode),
    .edit_active   (edit_active),
    .cursor        (cursor),
    .inc_strobe    (inc_strobe),
    .commit_strobe (commit_strobe),
    .cancel_strobe (cancel_strobe),
    .blank         (blank)
  );

  int checks = 0;
  int failures = 0;

  // Observed strobe counts, cleared by the sequences that inspect them.
  int cnt_inc, cnt_com, cnt_can;

  // Reference model. Button bits: 0 mode, 1 set, 2 next, 3 up.
  int m_mode, m_cursor, m_t, m_blank;
  bit m_edit, m_inc, m_com, m_can;
  bit m_stable [4];
  bit m_ev     [4];
  bit m_hist   [4][2+DEB];  // raw level seen at the last 2+DEB edges, [0] newest

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_cursor = 3; m_t = 0; m_blank = 0;
    m_edit = 0; m_inc = 0; m_com = 0; m_can = 0;
    for (int b = 0; b < 4; b++) begin
      m_stable[b] = 1; m_ev[b] = 0;
      for (int i = 0; i < 2 + DEB; i++) m_hist[b][i] = 1;
    end
  endfunction

  // One rising edge: act on the presses recognised at the previous edge,
  // then recognise new presses from the raw history.
  function automatic void model_edge(input bit [3:0] raw);
    bit any;
    bit flip;
    any = m_ev[0] | m_ev[1] | m_ev[2] | m_ev[3];
    m_inc = 0; m_com = 0; m_can = 0;
    if (!m_edit) begin
      if (m_ev[0]) m_mode = (m_mode + 1) % 4;
      else if (m_ev[1] && m_mode != 1) m_edit = 1;
      m_t = 0;
      m_cursor = 3;
    end else begin
      if (m_ev[0])                begin m_can = 1; m_edit = 0; end
      else if (m_ev[1])           begin m_com = 1; m_edit = 0; end
      else if (m_ev[2])           m_cursor = (m_cursor + 3) % 4;
      else if (m_ev[3])           m_inc = 1;
      else if (m_t + 1 >= IT)     begin m_can = 1; m_edit = 0; end
      m_t = any ? 0 : m_t + 1;
      if (!m_edit) begin m_cursor = 3; m_t = 0; end
    end
    m_blank = m_edit ? (((m_t / BH) % 2) << m_cursor) : 0;

    for (int b = 0; b < 4; b++) begin
      for (int i = 2 + DEB - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
      m_hist[b][0] = raw[b];
      m_ev[b] = 0;
      flip = 1;
      // Samples reach the debouncer two edges late (synchronizer).
      for (int i = 2; i < 2 + DEB; i++) if (m_hist[b][i] == m_stable[b]) flip = 0;
      if (flip) begin
        m_stable[b] = ~m_stable[b];
        m_ev[b] = m_stable[b];
      end
    end
  endfunction

  task automatic step(input bit [3:0] raw);
    btn_mode = raw[0]; btn_set = raw[1]; btn_next = raw[2]; btn_up = raw[3];
    @(posedge clk);
    #1;
    model_edge(raw);
    check("mode",        int'(mode),          m_mode);
    check("edit_active", int'(edit_active),   int'(m_edit));
    check("cursor",      int'(cursor),        m_cursor);
    check("inc_strobe",  int'(inc_strobe),    int'(m_inc));
    check("commit",      int'(commit_strobe), int'(m_com));
    check("cancel",      int'(cancel_strobe), int'(m_can));
    check("blank",       int'(blank),         m_blank);
    check("one_strobe",  int'(inc_strobe) + int'(commit_strobe) + int'(cancel_strobe) <= 1, 1);
    cnt_inc += int'(inc_strobe);
    cnt_com += int'(commit_strobe);
    cnt_can += int'(cancel_strobe);
  endtask

  task automatic hold(input bit [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  task automatic clear_counts();
    cnt_inc = 0; cnt_com = 0; cnt_can = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mode"},   int'(mode),        0);
    check({tag, "_edit"},   int'(edit_active), 0);
    check({tag, "_cursor"}, int'(cursor),      3);
    check({tag, "_strobe"}, int'(inc_strobe) + int'(commit_strobe) + int'(cancel_strobe), 0);
    check({tag, "_blank"},  int'(blank),       0);
  endtask

  // A segment: press for 10 cycles, release for 10. The press takes effect at
  // cycle 7, so an open edit session ends the segment 13 cycles into blink,
  // i.e. in the blanked half-period.
  typedef struct {
    bit [3:0] btn;
    int       mode;
    int       edit;
    int       cursor;
    int       blank;
    int       inc;
    int       com;
    int       can;
  } vec_t;

  vec_t tbl [0:21];

  task automatic run_row(input int r);
    clear_counts();
    hold(tbl[r].btn, 10);
    hold(4'b0000, 10);
    check($sformatf("row%0d_mode", r),   int'(mode),        tbl[r].mode);
    check($sformatf("row%0d_edit", r),   int'(edit_active), tbl[r].edit);
    check($sformatf("row%0d_cursor", r), int'(cursor),      tbl[r].cursor);
    check($sformatf("row%0d_blank", r),  int'(blank),       tbl[r].blank);
    check($sformatf("row%0d_inc", r),    cnt_inc,           tbl[r].inc);
    check($sformatf("row%0d_commit", r), cnt_com,           tbl[r].com);
    check($sformatf("row%0d_cancel", r), cnt_can,           tbl[r].can);
  endtask

  initial begin
    bit [3:0] raw;
    int n;

    //            btn      mode edit cur blank inc com can
    tbl[0]  = '{4'b0001, 1, 0, 3, 4'b0000, 0, 0, 0};
    tbl[1]  = '{4'b0001, 2, 0, 3, 4'b0000, 0, 0, 0};
    tbl[2]  = '{4'b0001, 3, 0, 3, 4'b0000, 0, 0, 0};
    tbl[3]  = '{4'b0001, 0, 0, 3, 4'b0000, 0, 0, 0};
    tbl[4]  = '{4'b0010, 0, 1, 3, 4'b1000, 0, 0, 0};
    tbl[5]  = '{4'b0100, 0, 1, 2, 4'b0100, 0, 0, 0};
    tbl[6]  = '{4'b0100, 0, 1, 1, 4'b0010, 0, 0, 0};
    tbl[7]  = '{4'b0100, 0, 1, 0, 4'b0001, 0, 0, 0};
    tbl[8]  = '{4'b0100, 0, 1, 3, 4'b1000, 0, 0, 0};
    tbl[9]  = '{4'b0100, 0, 1, 2, 4'b0100, 0, 0, 0};
    tbl[10] = '{4'b1000, 0, 1, 2, 4'b0100, 1, 0, 0};
    tbl[11] = '{4'b1000, 0, 1, 2, 4'b0100, 1, 0, 0};
    tbl[12] = '{4'b0010, 0, 0, 3, 4'b0000, 0, 1, 0};
    tbl[13] = '{4'b0001, 1, 0, 3, 4'b0000, 0, 0, 0};
    tbl[14] = '{4'b0010, 1, 0, 3, 4'b0000, 0, 0, 0};
    tbl[15] = '{4'b0001, 2, 0, 3, 4'b0000, 0, 0, 0};
    tbl[16] = '{4'b0010, 2, 1, 3, 4'b1000, 0, 0, 0};
    tbl[17] = '{4'b0010, 2, 1, 3, 4'b1000, 0, 0, 0};
    tbl[18] = '{4'b0010, 2, 1, 3, 4'b1000, 0, 0, 0};
    tbl[19] = '{4'b0100, 2, 1, 2, 4'b0100, 0, 0, 0};
    tbl[20] = '{4'b0100, 2, 1, 1, 4'b0010, 0, 0, 0};
    tbl[21] = '{4'b0010, 0, 1, 3, 4'b1000, 0, 0, 0};

    clear_counts();
    model_reset();
    #12;
    check_reset_values("reset");
    #1 reset = 1'b0;
    hold(4'b0000, 10);  // let the debounced levels settle to released

    // Mode cycling, then a full edit session.
    for (int r = 0; r <= 12; r++) run_row(r);
    // Stopwatch ignores set; alarm enters edit.
    for (int r = 13; r <= 16; r++) run_row(r);

    // Idle timeout in alarm mode.
    clear_counts();
    hold(4'b0000, 60);
    check("timeout_cancel", cnt_can, 1);
    check("timeout_other",  cnt_inc + cnt_com, 0);
    check("timeout_edit",   int'(edit_active), 0);
    check("timeout_mode",   int'(mode), 2);

    // Glitch versus real press on up.
    run_row(17);
    clear_counts();
    hold(4'b1000, 3);
    hold(4'b0000, 12);
    check("glitch_inc", cnt_inc, 0);
    clear_counts();
    for (int i = 1; i <= 10; i++) begin
      step(4'b1000);
      if (i == 6) check("inc_early", int'(inc_strobe), 0);
      if (i == 7) check("inc_at_7",  int'(inc_strobe), 1);
    end
    hold(4'b0000, 10);
    check("press_inc", cnt_inc, 1);

    // Mode and up recognised together: mode wins.
    clear_counts();
    hold(4'b1001, 10);
    hold(4'b0000, 10);
    check("same_cancel", cnt_can, 1);
    check("same_inc",    cnt_inc + cnt_com, 0);
    check("same_mode",   int'(mode), 2);
    check("same_edit",   int'(edit_active), 0);

    // Reset mid-session with set held through it.
    for (int r = 18; r <= 20; r++) run_row(r);
    btn_set = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    #2 reset = 1'b0;
    model_reset();
    clear_counts();
    hold(4'b0010, 20);
    check("held_edit",    int'(edit_active), 0);
    check("held_strobes", cnt_inc + cnt_com + cnt_can, 0);
    hold(4'b0000, 10);
    run_row(21);

    // Randomized activity against the model.
    for (int k = 0; k < 300; k++) begin
      raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) raw = 4'b0000;
      n = $urandom_range(1, 12);
      hold(raw, n);
      if ($urandom_range(0, 19) == 0) hold(4'b0000, 70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
